// File: rtl/scene_sequencer.sv
// rtl/scene_sequencer.sv - per-frame sprite scene sequencer
//
// Steps the intro/run scene once per video frame and drives the layer
// offsets consumed by the sprite layer instances.
// Optional feature macro: SEQ_DEBOUNCE_EN (synchronized, frame-sampled lane buttons).
//
// Ports:
//   CLK100MHZ    in   system clock
//   CPU_RESETN   in   asynchronous active-low reset
//   vsync        in   VGA vertical sync (asynchronous)
//   BTNL, BTNR   in   lane buttons (level)
//   frame_tick   out  one-cycle pulse per vsync rising edge
//   state        out  COUNT=0 LOGO=1 HEAD=2 ARM=3 RUN=4
//   logo_voffset out  logo vertical offset (12-bit signed)
//   head_hoffset out  head horizontal (lane) offset (12-bit signed)
//   head_voffset out  head vertical offset (12-bit signed)
//   coin_loc     out  coin progress (12-bit signed)
//   coin_flip    out  coin flip toggle
module scene_sequencer #(
  parameter int COUNTDOWN_FRAMES = 5,
  parameter int LOGO_STEP        = 30,
  parameter int LOGO_END         = 640,
  parameter int HEAD_START       = 180,
  parameter int HEAD_STEP        = 17,
  parameter int HEAD_END         = 50,
  parameter int LANE_OFFSET      = 100,
  parameter int COIN_MAX         = 100
) (
  input  logic               CLK100MHZ,
  input  logic               CPU_RESETN,
  input  logic               vsync,
  input  logic               BTNL,
  input  logic               BTNR,
  output logic               frame_tick,
  output logic [2:0]         state,
  output logic signed [11:0] logo_voffset,
  output logic signed [11:0] head_hoffset,
  output logic signed [11:0] head_voffset,
  output logic signed [11:0] coin_loc,
  output logic               coin_flip
);

  typedef enum logic [2:0] {
    ST_COUNT = 3'd0,
    ST_LOGO  = 3'd1,
    ST_HEAD  = 3'd2,
    ST_ARM   = 3'd3,
    ST_RUN   = 3'd4
  } state_t;

  localparam logic signed [11:0] LOGO_STEP_S  = 12'(LOGO_STEP);
  localparam logic signed [11:0] LOGO_END_S   = 12'(LOGO_END);
  localparam logic signed [11:0] HEAD_START_S = 12'(HEAD_START);
  localparam logic signed [11:0] HEAD_STEP_S  = 12'(HEAD_STEP);
  localparam logic signed [11:0] HEAD_END_S   = 12'(HEAD_END);
  localparam logic signed [11:0] COIN_MAX_S   = 12'(COIN_MAX);
  localparam logic signed [11:0] COIN_RESET_S = -12'sd50;
  localparam logic signed [11:0] LANE_POS     = 12'(LANE_OFFSET);
  localparam logic signed [11:0] LANE_NEG     = -LANE_POS;

  state_t      st;
  logic [15:0] count;

  // vsync synchronizer plus history flop. All reset to 1 so that a vsync
  // already high at reset release is not mistaken for a new frame.
  logic vs_meta, vs_sync, vs_hist;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_hist <= 1'b1;
    end else begin
      vs_meta <= vsync;
      vs_sync <= vs_meta;
      vs_hist <= vs_sync;
    end
  end

  // Function of flops only; no path from any input pin.
  assign frame_tick = vs_sync & ~vs_hist;
  assign state      = st;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      st           <= ST_COUNT;
      count        <= 16'(COUNTDOWN_FRAMES);
      logo_voffset <= '0;
      head_voffset <= HEAD_START_S;
      coin_loc     <= COIN_RESET_S;
      coin_flip    <= 1'b0;
    end else if (frame_tick) begin
      case (st)
        ST_COUNT: begin
          if (count != '0) count <= count - 16'd1;
          else             st    <= ST_LOGO;
        end
        ST_LOGO: begin
          if (logo_voffset >= LOGO_END_S) st <= ST_HEAD;
          else logo_voffset <= logo_voffset + LOGO_STEP_S;
        end
        ST_HEAD: begin
          if (head_voffset <= HEAD_END_S) st <= ST_ARM;
          else head_voffset <= head_voffset - HEAD_STEP_S;
        end
        ST_ARM: begin
          coin_loc <= '0;
          st       <= ST_RUN;
        end
        ST_RUN: begin
          coin_flip <= ~coin_flip;
          coin_loc  <= (coin_loc == COIN_MAX_S) ? 12'sd0 : coin_loc + 12'sd1;
        end
        default: st <= ST_COUNT;
      endcase
    end
  end

`ifdef SEQ_DEBOUNCE_EN
  // Buttons are synchronized, the lane code is sampled once per frame, and
  // the offset only follows a code seen on two consecutive frames.
  logic [1:0] btnl_sync, btnr_sync;
  logic [1:0] lane_code, lane_prev;

  // 01 = left (wins over right), 10 = right, 00 = centre
  assign lane_code = btnl_sync[1] ? 2'b01 : (btnr_sync[1] ? 2'b10 : 2'b00);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      btnl_sync    <= '0;
      btnr_sync    <= '0;
      lane_prev    <= '0;
      head_hoffset <= '0;
    end else begin
      btnl_sync <= {btnl_sync[0], BTNL};
      btnr_sync <= {btnr_sync[0], BTNR};
      if (frame_tick) begin
        lane_prev <= lane_code;
        if (lane_code == lane_prev) begin
          case (lane_code)
            2'b01:   head_hoffset <= LANE_NEG;
            2'b10:   head_hoffset <= LANE_POS;
            default: head_hoffset <= '0;
          endcase
        end
      end
    end
  end
`else
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN)  head_hoffset <= '0;
    else if (BTNL)    head_hoffset <= LANE_NEG;
    else if (BTNR)    head_hoffset <= LANE_POS;
    else              head_hoffset <= '0;
  end
`endif

endmodule

// File: tb/tb_scene_sequencer.sv
// tb/tb_scene_sequencer.sv - scoreboard bench for scene_sequencer
module tb_scene_sequencer;

  logic               CLK100MHZ = 1'b0;
  logic               CPU_RESETN;
  logic               vsync;
  logic               BTNL;
  logic               BTNR;
  logic               frame_tick;
  logic [2:0]         state;
  logic signed [11:0] logo_voffset;
  logic signed [11:0] head_hoffset;
  logic signed [11:0] head_voffset;
  logic signed [11:0] coin_loc;
  logic               coin_flip;

  scene_sequencer dut (
    .CLK100MHZ    (CLK100MHZ),
    .CPU_RESETN   (CPU_RESETN),
    .vsync        (vsync),
    .BTNL         (BTNL),
    .BTNR         (BTNR),
    .frame_tick   (frame_tick),
    .state        (state),
    .logo_voffset (logo_voffset),
    .head_hoffset (head_hoffset),
    .head_voffset (head_voffset),
    .coin_loc     (coin_loc),
    .coin_flip    (coin_flip)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    int n;
    int st;
    int logo;
    int headv;
    int coin;
    int flip;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_ticks = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Expected outputs after the n-th tick since reset, from the frame
  // thresholds of the default parameter set.
  function automatic exp_t model(input int n);
    exp_t e;
    e.n     = n;
    e.st    = (n < 6) ? 0 : (n < 29) ? 1 : (n < 38) ? 2 : (n < 39) ? 3 : 4;
    e.logo  = (n <= 6) ? 0 : (n <= 28) ? 30 * (n - 6) : 660;
    e.headv = (n <= 29) ? 180 : (n <= 37) ? 180 - 17 * (n - 29) : 44;
    e.coin  = (n < 39) ? -50 : (n - 39) % 101;
    e.flip  = (n <= 39) ? 0 : (n - 39) % 2;
    return e;
  endfunction

  // Monitor: every frame_tick is a response; outputs are checked the cycle after.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK100MHZ);
      if (frame_tick === 1'b1) begin
        @(negedge CLK100MHZ);
        if (sb_q.size() == 0) begin
          chk("unexpected_tick", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk($sformatf("state@%0d", e.n), int'(state), e.st);
          chk($sformatf("logo@%0d", e.n), int'(logo_voffset), e.logo);
          chk($sformatf("headv@%0d", e.n), int'(head_voffset), e.headv);
          chk($sformatf("coin@%0d", e.n), int'(coin_loc), e.coin);
          chk($sformatf("flip@%0d", e.n), int'(coin_flip), e.flip);
        end
      end
    end
  end

  task automatic pulse_vsync();
    int lat;
    lat = 0;
    n_ticks++;
    sb_q.push_back(model(n_ticks));
    @(posedge CLK100MHZ); #2;
    vsync = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK100MHZ);
      if (frame_tick === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("tick_latency_2to3", int'(lat >= 2 && lat <= 3), 1);
    repeat (2) @(posedge CLK100MHZ);
    #2 vsync = 1'b0;
    repeat (6) @(posedge CLK100MHZ);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_logo"}, int'(logo_voffset), 0);
    chk({tag, "_headv"}, int'(head_voffset), 180);
    chk({tag, "_coin"}, int'(coin_loc), -50);
    chk({tag, "_flip"}, int'(coin_flip), 0);
    chk({tag, "_hoff"}, int'(head_hoffset), 0);
    chk({tag, "_tick"}, int'(frame_tick), 0);
  endtask

  task automatic lane_step(input logic l, input logic r, input int expv, input string name);
    @(posedge CLK100MHZ); #2;
    BTNL = l;
    BTNR = r;
    @(posedge CLK100MHZ); #1;
    chk(name, int'(head_hoffset), expv);
  endtask

  initial begin
    int tick_cnt;
    CPU_RESETN = 1'b0;
    vsync      = 1'b1;
    BTNL       = 1'b0;
    BTNR       = 1'b0;
    repeat (3) @(posedge CLK100MHZ);
    #2 CPU_RESETN = 1'b1;

    // vsync high across reset release: no frame detected
    tick_cnt = 0;
    repeat (100) begin
      @(negedge CLK100MHZ);
      if (frame_tick === 1'b1) tick_cnt++;
    end
    chk("no_tick_after_reset", tick_cnt, 0);
    check_reset_values("rst");

    #2 vsync = 1'b0;
    repeat (6) @(posedge CLK100MHZ);

    // full intro sequence and coin wrap
    repeat (140) pulse_vsync();

`ifdef SEQ_DEBOUNCE_EN
    pulse_vsync();
    pulse_vsync();
    chk("deb_idle", int'(head_hoffset), 0);
    BTNR = 1'b1;
    repeat (3) @(posedge CLK100MHZ);
    pulse_vsync();
    chk("deb_one_tick", int'(head_hoffset), 0);
    pulse_vsync();
    chk("deb_two_ticks", int'(head_hoffset), 100);
    BTNR = 1'b0;
    pulse_vsync();
    pulse_vsync();
    chk("deb_release", int'(head_hoffset), 0);
    BTNR = 1'b1;
    repeat (3) @(posedge CLK100MHZ);
    pulse_vsync();
    BTNR = 1'b0;
    repeat (3) @(posedge CLK100MHZ);
    pulse_vsync();
    chk("deb_glitch", int'(head_hoffset), 0);
`else
    lane_step(1'b1, 1'b0, -100, "lane_left");
    lane_step(1'b1, 1'b1, -100, "lane_both");
    lane_step(1'b0, 1'b1, 100, "lane_right");
    lane_step(1'b0, 1'b0, 0, "lane_none");
`endif

    // restart from reset, then reset asynchronously during HEAD
    @(posedge CLK100MHZ); #3 CPU_RESETN = 1'b0;
    @(posedge CLK100MHZ); #2 CPU_RESETN = 1'b1;
    n_ticks = 0;
    repeat (33) pulse_vsync();
    chk("mid_state_head", int'(state), 2);
    @(posedge CLK100MHZ); #3;
    CPU_RESETN = 1'b0;
    #1;
    check_reset_values("async");
    repeat (2) @(posedge CLK100MHZ);
    #2 CPU_RESETN = 1'b1;
    n_ticks = 0;
    repeat (5) pulse_vsync();
    chk("count_after_5", int'(state), 0);
    pulse_vsync();
    chk("logo_after_6", int'(state), 1);

    repeat (4) @(posedge CLK100MHZ);
    chk("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/scene_sequencer.md
# scene_sequencer

Per-frame scene controller that sequences the sprite layer stack (background, logo, head, coin) through the intro and run phases. It detects frame boundaries from the VGA vertical sync in the system clock domain and steps a state machine once per frame. It drives the registered offset and flip controls consumed by the `layer` instances, and maps the lane buttons to the head sprite's horizontal offset.

## Interface
- `COUNTDOWN_FRAMES`, 5: idle frames before the logo slide.
- `LOGO_STEP`, 30: logo vertical offset increment per frame.
- `LOGO_END`, 640: logo offset threshold that ends the slide.
- `HEAD_START`, 180: head vertical offset at reset.
- `HEAD_STEP`, 17: head vertical offset decrement per frame.
- `HEAD_END`, 50: head offset threshold that ends the rise.
- `LANE_OFFSET`, 100: magnitude of the head horizontal offset for a lane shift.
- `COIN_MAX`, 100: coin position at which the coin wraps back to 0.
- `CLK100MHZ  in  1`: system clock; every register is on its rising edge.
- `CPU_RESETN  in  1`: asynchronous, active-low reset.
- `vsync  in  1`: VGA vertical sync, treated as asynchronous.
- `BTNL  in  1`: left-lane button, level.
- `BTNR  in  1`: right-lane button, level.
- `frame_tick  out  1`: one-cycle pulse per vsync rising edge.
- `state  out  3`: COUNT=0, LOGO=1, HEAD=2, ARM=3, RUN=4.
- `logo_voffset  out  12 signed`: logo layer vertical offset.
- `head_hoffset  out  12 signed`: head layer horizontal offset (lane).
- `head_voffset  out  12 signed`: head layer vertical offset.
- `coin_loc  out  12 signed`: coin progress; the top level derives the per-replica coin offsets from it.
- `coin_flip  out  1`: coin flip toggle.

## Operation
- **Frame detect.** `vsync` goes through a 2-flop synchronizer, then a history flop; `frame_tick` = sync & ~history.
  - All three flops reset to 1, so releasing reset while `vsync` is high produces no tick.
- **Reset values.** state=COUNT, internal count=`COUNTDOWN_FRAMES`, logo_voffset=0, head_voffset=`HEAD_START`, coin_loc=-50, coin_flip=0, head_hoffset=0, frame_tick=0.
- **FSM.** The FSM acts only in cycles where `frame_tick`=1; exactly one action is taken per tick.
  - **COUNT:** if count≠0, count−=1; else go to LOGO.
  - **LOGO:** if logo_voffset ≥ `LOGO_END`, go to HEAD; else logo_voffset += `LOGO_STEP`. With default parameters the final value is 660.
  - **HEAD:** if head_voffset ≤ `HEAD_END`, go to ARM; else head_voffset −= `HEAD_STEP`. With default parameters the final value is 44.
  - **ARM:** coin_loc := 0, go to RUN.
  - **RUN:** coin_flip toggles. coin_loc := 0 if coin_loc = `COIN_MAX`, else coin_loc+1. RUN is terminal until reset.
- **Arithmetic.** All offsets are 12-bit two's complement. Parameters must keep every value inside ±2047; no saturation logic is provided.
- **Lane.** head_hoffset is evaluated every clock, independent of state:
  - BTNL=1 → −`LANE_OFFSET`. BTNL wins when both buttons are pressed.
  - BTNR=1 only → +`LANE_OFFSET`.
  - Neither → 0.
- **Reset mid-operation.** Asserting `CPU_RESETN` low clears everything immediately, in any state, independent of the clock. The FSM restarts in COUNT on the first tick after release.

## Timing
- `vsync` rise → `frame_tick` high: 2–3 clocks, depending on sampling phase.
- `frame_tick` high in cycle N → state and offset outputs update at the end of cycle N and are visible in cycle N+1.
- All outputs are registered; there are no combinational paths from input to output.
- Lane latency is 1 clock from a button change to head_hoffset, unless `SEQ_DEBOUNCE_EN` is defined.
- Back-to-back ticks cannot occur: vsync has a period far above 4 clocks.
- Tick counts with default parameters:
  - LOGO is entered on tick 6.
  - HEAD is entered on tick 29.
  - ARM is entered on tick 38.
  - RUN is entered on tick 39, with coin_loc=0.

## Configuration
- `SEQ_DEBOUNCE_EN` defined:
  - Buttons pass through a 2-flop synchronizer.
  - The lane code (L/R/none) is sampled only on `frame_tick`.
  - head_hoffset changes only when the same code is seen on two consecutive ticks; it updates in the cycle after the second tick.
- `SEQ_DEBOUNCE_EN` undefined: lane mapping is per-clock as described in Operation. No extra flops.

## Test plan
- **Reset/no-tick:**
  - Hold vsync high through reset release → no `frame_tick` for 100 clocks.
  - All outputs stay at their reset values: head_voffset=180, coin_loc=−50.
- **Full sequence:** pulse vsync 45 times.
  - state reaches LOGO at tick 6, HEAD at 29, ARM at 38, RUN at 39.
  - logo_voffset=660 and head_voffset=44 at the end.
  - After tick 45: coin_loc=6, coin_flip=0.
- **Coin wrap:** continue to 140 ticks → coin_loc goes 100 then 0 on the next tick; coin_flip toggles on every RUN tick.
- **Lane priority (no macro):**
  - BTNL=1 → head_hoffset=−100 after 1 clock.
  - BTNL=BTNR=1 → −100.
  - BTNR only → +100.
  - Release both → 0.
- **Mid-run reset:** assert `CPU_RESETN`=0 during HEAD at tick 33 → outputs return to reset values asynchronously; after release, 6 ticks are needed to reach LOGO again.
- **Debounce (`SEQ_DEBOUNCE_EN`):**
  - BTNR held across ticks k, k+1 → +100 one cycle after tick k+1.
  - BTNR pressed for a single tick window → head_hoffset stays 0.
